cond_logic: RTL
===============

# cond_logic

Conditional-execution unit of the multicycle core; sits directly downstream of the instruction decoder. Holds the architectural NZCV flag register and evaluates the 4-bit condition field of the current instruction against it. It converts the decoder's raw write requests (FlagW, PCS, NextPC, RegW, MemW) into the final PCWrite, RegWrite and MemWrite enables for the datapath. The condition result is registered so that a write-back or memory cycle uses the condition as evaluated before the same instruction updated the flags.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- Cond  in  4  condition field, instruction bits [31:28], from the instruction register.
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
- FlagW  in  2  from decoder; [1] requests an N,Z update, [0] requests a C,V update.
- PCS  in  1  from decoder; the instruction writes the PC (branch, or a data-processing op with Rd = 15).
- NextPC  in  1  from decoder FSM; unconditional PC increment (fetch cycle).
- RegW  in  1  from decoder FSM; register-file write request.
- MemW  in  1  from decoder FSM; data-memory write request.
- PCWrite  out  1  final PC write enable.
- RegWrite  out  1  final register-file write enable.
- MemWrite  out  1  final memory write enable.
- Flags  out  4  current {N,Z,C,V} register contents, for debug and bench observation.
- CondEx  out  1  combinational condition result for the current Cond and Flags.

## Operation
- State: Flags[3:0] and CondExD (1 bit), both asynchronously cleared while reset = 0.
- CondEx is combinational from Cond and the registered Flags (never from ALUFlags):
  - 0000 EQ: Z. 0001 NE: !Z. 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N. 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C & !Z. 1001 LS: !(C & !Z).
  - 1010 GE: N == V. 1011 LT: N != V.
  - 1100 GT: !Z & (N == V). 1101 LE: Z | (N != V).
  - 1110 AL: 1. 1111: 1, treated as unconditional.
- Flag update, rising edge:
  - Flags[3:2] <= ALUFlags[3:2] when FlagW[1] & CondEx.
  - Flags[1:0] <= ALUFlags[1:0] when FlagW[0] & CondEx.
  - Otherwise each half holds its value. The two halves are independent.
- CondExD <= CondEx on every rising edge out of reset.
- Write enables, combinational:
  - PCWrite = (PCS & CondExD) | NextPC.
  - RegWrite = RegW & CondExD.
  - MemWrite = MemW & CondExD.
- While reset = 0, PCWrite, RegWrite and MemWrite are forced to 0, including the NextPC path.

## Timing
- Reset values: Flags = 0000, CondExD = 0, PCWrite = RegWrite = MemWrite = 0.
- CondEx after reset with Flags = 0000: 1 for NE, CC, PL, VC, LS, GE, GT, AL and 1111; 0 for all other codes.
- Reset release: the first edge with reset = 1 loads CondExD, so conditional writes are blocked for the cycle immediately after deassertion. NextPC passes in that cycle.
- Flag latency: flags written at edge k are visible on Flags and affect CondEx in cycle k+1.
- Write-enable latency: a conditional write uses the CondEx registered at the previous edge, i.e. evaluated in the preceding FSM state (execute), before that state's flag update.
- Simultaneous events: FlagW and a condition change in the same cycle use the pre-update Flags for gating.
- A failing condition suppresses both the flag write and the later write-back of the same instruction.
- NextPC is never gated by the condition.
- Reset asserted mid-instruction: state clears immediately and asynchronously, and all write enables drop in the same cycle.

## Test plan
- Reset, then Cond = 0000 with Flags = 0000: CondEx = 0. Next cycle RegW = 1 gives RegWrite = 0. With NextPC = 1, PCWrite = 1 only once reset = 1.
- Flags = 0000. Cycle 1: ALUFlags = 0100, FlagW = 11, Cond = 1110. Cycle 2: Flags = 0100 and Cond = 0000 gives CondEx = 1. Cycle 3: RegW = 1 gives RegWrite = 1.
- Partial update: Flags = 1111, ALUFlags = 0000, FlagW = 10, Cond = 1110 gives Flags = 0011 next cycle.
- Self-update isolation: Flags = 0000, Cond = 0001 (NE), FlagW = 11, ALUFlags = 0100 in execute. Write-back next cycle with RegW = 1 gives RegWrite = 1, because CondExD was captured pre-update; Flags = 0100.
- Condition sweep: for all 16 Flags values × 16 Cond values, CondEx matches the table above (256 checks).
- Failing branch: Flags = 0100, Cond = 0001, PCS = 1, NextPC = 0 gives PCWrite = 0 the next cycle. Same stimulus with MemW = 1 gives MemWrite = 0, and FlagW = 11 leaves Flags unchanged.

Source files
------------

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds the NZCV flag register, evaluates the
// instruction condition field and gates the decoder's write requests with it.
module cond_logic (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondEx
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    logic [3:0] flags_q, flags_d;
    logic       condexd_q, condexd_d;
    logic       n, z, c, v;
    cond_e      cond;

    assign {n, z, c, v} = flags_q;
    assign cond         = cond_e'(Cond);

    always_comb begin
        CondEx = 1'b0;
        unique case (cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~(c & ~z);
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b1;
            default: CondEx = 1'b1;
        endcase
    end

    // NZ and CV halves update independently, both gated by the current condition
    always_comb begin
        flags_d   = flags_q;
        condexd_d = CondEx;
        if (FlagW[1] & CondEx) flags_d[3:2] = ALUFlags[3:2];
        if (FlagW[0] & CondEx) flags_d[1:0] = ALUFlags[1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q   <= '0;
            condexd_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            condexd_q <= condexd_d;
        end
    end

    // Enables drop asynchronously with reset, including the NextPC path
    always_comb begin
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        if (reset) begin
            PCWrite  = (PCS & condexd_q) | NextPC;
            RegWrite = RegW & condexd_q;
            MemWrite = MemW & condexd_q;
        end
    end

    assign Flags = flags_q;

endmodule
